product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 126 ++++++++++++
 tb/tb_product_accumulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Signed product accumulator: sums a run of `len` products from an upstream
// multiplier with saturation, then holds the result until it is consumed.
module product_accumulator #(
  parameter int P_WIDTH   = 64,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 p_valid,
  input  logic [P_WIDTH-1:0]   p_data,
  output logic                 p_ready,
  output logic                 acc_valid,
  output logic [P_WIDTH-1:0]   acc_data,
  input  logic                 acc_ready,
  output logic                 ovf,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [P_WIDTH-1:0] SAT_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [P_WIDTH-1:0] SAT_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

  logic [1:0]           state_q,     state_d;
  logic [P_WIDTH-1:0]   acc_q,       acc_d;
  logic [LEN_WIDTH-1:0] cnt_q,       cnt_d;
  logic                 ovf_q,       ovf_d;
  logic                 p_ready_q,   p_ready_d;
  logic                 acc_valid_q, acc_valid_d;
  logic                 busy_q,      busy_d;

  logic [P_WIDTH:0]     sum_wide;
  logic                 sum_ovf;
  logic [P_WIDTH-1:0]   sum_sat;

  // Sign-extended add one bit wider than the accumulator, clamped on overflow.
  always_comb begin
    sum_wide = {acc_q[P_WIDTH-1], acc_q} + {p_data[P_WIDTH-1], p_data};
    sum_ovf  = sum_wide[P_WIDTH] ^ sum_wide[P_WIDTH-1];
    if (!sum_ovf) begin
      sum_sat = sum_wide[P_WIDTH-1:0];
    end else if (sum_wide[P_WIDTH]) begin
      sum_sat = SAT_MIN;
    end else begin
      sum_sat = SAT_MAX;
    end
  end

  // Next-state and datapath update; output flags are precomputed from the
  // next state so every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = len;
          if (len == '0) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (p_valid) begin
          acc_d = sum_sat;
          if (sum_ovf) begin
            ovf_d = 1'b1;
          end
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (acc_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    p_ready_d   = (state_d == ST_ACCUM);
    acc_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      p_ready_q   <= 1'b0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      p_ready_q   <= p_ready_d;
      acc_valid_q <= acc_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign p_ready   = p_ready_q;
  assign acc_valid = acc_valid_q;
  assign acc_data  = acc_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed runs, a cycle-level behavioural
// model compared on every falling edge, and literal result checks.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        p_valid = 1'b0;
  logic [63:0] p_data = '0;
  logic        p_ready;
  logic        acc_valid;
  logic [63:0] acc_data;
  logic        acc_ready = 1'b0;
  logic        ovf;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic signed [64:0] MAXV = (65'sd1 <<< 63) - 65'sd1;
  localparam logic signed [64:0] MINV = -(65'sd1 <<< 63);

  product_accumulator #(.P_WIDTH(64), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_ready(acc_ready),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run/result bookkeeping with wide signed arithmetic.
  logic               m_running = 1'b0;
  logic               m_result  = 1'b0;
  logic signed [63:0] m_acc     = '0;
  logic               m_ovf     = 1'b0;
  int                 m_left    = 0;

  always @(posedge clk or negedge rst) begin
    logic signed [64:0] wide;
    if (!rst) begin
      m_running = 1'b0; m_result = 1'b0; m_acc = '0; m_ovf = 1'b0; m_left = 0;
    end else if (m_result) begin
      if (acc_ready) m_result = 1'b0;
    end else if (m_running) begin
      if (p_valid) begin
        wide = m_acc;
        wide = wide + $signed(p_data);
        if (wide > MAXV) begin
          m_acc = MAX64; m_ovf = 1'b1;
        end else if (wide < MINV) begin
          m_acc = MIN64; m_ovf = 1'b1;
        end else begin
          m_acc = wide[63:0];
        end
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_running = 1'b0; m_result = 1'b1;
        end
      end
    end else if (start) begin
      m_acc = '0; m_ovf = 1'b0;
      if (len == 8'd0) m_result = 1'b1;
      else begin
        m_running = 1'b1; m_left = int'(len);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_p_ready",   64'(p_ready),   64'(m_running));
    chk("cmp_acc_valid", 64'(acc_valid), 64'(m_result));
    chk("cmp_busy",      64'(busy),      64'(m_running | m_result));
    chk("cmp_acc_data",  acc_data,       m_acc);
    chk("cmp_ovf",       64'(ovf),       64'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0; len = '0;
  endtask

  task automatic push(input logic [63:0] d);
    p_valid = 1'b1; p_data = d;
    tick();
    p_valid = 1'b0; p_data = '0;
  endtask

  task automatic take_result();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_p_ready"},   64'(p_ready),   64'd0);
    chk({tag, "_acc_valid"}, 64'(acc_valid), 64'd0);
    chk({tag, "_acc_data"},  acc_data,       64'd0);
    chk({tag, "_ovf"},       64'(ovf),       64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  initial begin
    #3;
    chk_zero_outputs("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Basic run of three products.
    do_start(8'd3);
    chk("run3_busy", 64'(busy), 64'd1);
    chk("run3_p_ready", 64'(p_ready), 64'd1);
    push(64'd1500);
    push(64'd2064);
    chk("run3_not_yet_valid", 64'(acc_valid), 64'd0);
    push(-64'sd345);
    chk("run3_valid", 64'(acc_valid), 64'd1);
    chk("run3_data", acc_data, 64'h0000_0000_0000_0C93);
    chk("run3_ovf", 64'(ovf), 64'd0);
    chk("run3_model", m_acc, 64'd3219);
    tick();
    chk("run3_hold_valid", 64'(acc_valid), 64'd1);
    take_result();
    chk("run3_idle_valid", 64'(acc_valid), 64'd0);
    chk("run3_idle_busy", 64'(busy), 64'd0);
    chk("run3_idle_data", acc_data, 64'd3219);

    // Positive saturation, then a clean run clears ovf.
    do_start(8'd2);
    push(MAX64);
    push(64'd1);
    chk("satp_data", acc_data, MAX64);
    chk("satp_ovf", 64'(ovf), 64'd1);
    take_result();
    chk("satp_ovf_sticky", 64'(ovf), 64'd1);
    do_start(8'd1);
    chk("clr_ovf_on_start", 64'(ovf), 64'd0);
    push(-64'sd750);
    chk("neg_data", acc_data, 64'hFFFF_FFFF_FFFF_FD12);
    chk("neg_ovf", 64'(ovf), 64'd0);
    chk("neg_model", m_acc, 64'hFFFF_FFFF_FFFF_FD12);
    take_result();

    // Negative saturation.
    do_start(8'd2);
    push(MIN64);
    push(-64'sd1);
    chk("satn_data", acc_data, MIN64);
    chk("satn_ovf", 64'(ovf), 64'd1);
    take_result();

    // Accumulation continues from the clamped value.
    do_start(8'd3);
    push(64'h7FFF_FFFF_FFFF_FFF0);
    push(64'h20);
    push(-64'sd5);
    chk("cont_data", acc_data, 64'h7FFF_FFFF_FFFF_FFFA);
    chk("cont_ovf", 64'(ovf), 64'd1);
    chk("cont_model", m_acc, 64'h7FFF_FFFF_FFFF_FFFA);
    take_result();

    // Zero-length run: immediate result, held while not consumed.
    do_start(8'd0);
    chk("len0_busy", 64'(busy), 64'd1);
    chk("len0_valid", 64'(acc_valid), 64'd1);
    chk("len0_data", acc_data, 64'd0);
    chk("len0_ovf", 64'(ovf), 64'd0);
    p_valid = 1'b1; p_data = 64'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("len0_hold_valid", 64'(acc_valid), 64'd1);
      chk("len0_hold_data", acc_data, 64'd0);
    end
    p_valid = 1'b0; p_data = '0;
    take_result();
    chk("len0_idle_valid", 64'(acc_valid), 64'd0);
    chk("len0_idle_busy", 64'(busy), 64'd0);

    // Gaps in p_valid and a start pulse during ACCUM.
    do_start(8'd2);
    push(-64'sd2250);
    start = 1'b1; len = 8'd7;
    tick();
    start = 1'b0; len = '0;
    tick();
    chk("gap_p_ready", 64'(p_ready), 64'd1);
    chk("gap_valid", 64'(acc_valid), 64'd0);
    push(64'd2500);
    chk("gap_valid_done", 64'(acc_valid), 64'd1);
    chk("gap_data", acc_data, 64'd250);
    take_result();
    tick();
    chk("gap_no_rerun", 64'(busy), 64'd0);

    // Reset mid-run abandons the run.
    do_start(8'd4);
    push(64'd11);
    push(64'd22);
    #2 rst = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_valid", 64'(acc_valid), 64'd0);
    do_start(8'd1);
    push(64'd10);
    chk("post_rst_data", acc_data, 64'd10);
    chk("post_rst_valid2", 64'(acc_valid), 64'd1);
    take_result();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
